// File: rtl/tick_pkg.sv
// tick_pkg: register offsets and bit positions shared by the tick divider bank
package tick_pkg;
  typedef enum logic [1:0] {OFF_DIV_LO, OFF_DIV_HI, OFF_CTRL, OFF_STAT} off_e;
  localparam int CTRL_EN = 0;
  localparam int CTRL_ONESHOT = 1;
  localparam int CTRL_LOAD = 2;
  localparam int CTRL_CLR = 3;
  localparam int STAT_FLAG = 0;
  localparam int STAT_SQ = 1;
  localparam int STAT_EN = 2;
endpackage

// File: rtl/tick_chan.sv
// tick_chan: one programmable tick channel with shadowed divisor and sticky flag
module tick_chan
  import tick_pkg::*;
#(
  parameter int DIV_W = 28,
  parameter int DEF_DIV = 50_000,
  parameter bit DEF_EN = 1'b0
) (
  input  logic        clk50,
  input  logic        reset_n,
  input  logic        we,
  input  logic        re,
  input  off_e        off,
  input  logic [15:0] wdt,
  output logic [15:0] rdt,
  output logic        tick,
  output logic        sq,
  output logic        flag
);
  logic [DIV_W-1:0] shadow, act_div, cnt, div;
  logic en, oneshot, wr_ctrl, ld, clr;
  logic [15:0] ctrl_rd, stat_rd;
  assign div = (act_div == '0) ? DIV_W'(1) : act_div;
  // >= so a count held past a shrunken divisor still terminates
  assign tick = en && (cnt >= div - DIV_W'(1));
  assign wr_ctrl = we && off == OFF_CTRL;
  assign ld = wr_ctrl && wdt[CTRL_LOAD];
  assign clr = wr_ctrl && wdt[CTRL_CLR];
  always_comb begin
    ctrl_rd = '0;
    ctrl_rd[CTRL_EN] = en;
    ctrl_rd[CTRL_ONESHOT] = oneshot;
    stat_rd = '0;
    stat_rd[STAT_FLAG] = flag;
    stat_rd[STAT_SQ] = sq;
    stat_rd[STAT_EN] = en;
    rdt = (off == OFF_DIV_LO) ? shadow[15:0] :
          (off == OFF_DIV_HI) ? 16'(shadow[DIV_W-1:16]) :
          (off == OFF_CTRL)   ? ctrl_rd : stat_rd;
  end
  always_ff @(posedge clk50 or negedge reset_n)
    if (!reset_n) begin
      shadow <= DIV_W'(DEF_DIV);
      act_div <= DIV_W'(DEF_DIV);
      cnt <= '0;
      en <= DEF_EN;
      oneshot <= 1'b0;
      sq <= 1'b0;
      flag <= 1'b0;
    end else begin
      if (we && off == OFF_DIV_LO) shadow[15:0] <= wdt;
      if (we && off == OFF_DIV_HI) shadow[DIV_W-1:16] <= wdt[DIV_W-17:0];
      if (ld || tick || !en) act_div <= shadow;
      cnt <= (ld || clr || tick) ? '0 : en ? cnt + DIV_W'(1) : cnt;
      sq <= clr ? 1'b0 : sq ^ tick;
      flag <= tick || (flag && !(re && off == OFF_STAT));
      en <= wr_ctrl ? wdt[CTRL_EN] : en && !(tick && oneshot);
      if (wr_ctrl) oneshot <= wdt[CTRL_ONESHOT];
    end
endmodule

// File: rtl/tick_div_bank.sv
// tick_div_bank: bank of programmable tick/enable channels on the td4 I/O bus
module tick_div_bank
  import tick_pkg::*;
#(
  parameter int NCH = 4,
  parameter int DIV_W = 28,
  parameter logic [7:0] IO_BASE = 8'h40,
  parameter int DEF_DIV = 50_000,
  parameter bit DEF_EN = 1'b0
) (
  input  logic           clk50,
  input  logic           reset_n,
  input  logic [7:0]     ioad,
  input  logic [15:0]    iowdt,
  input  logic           iow,
  input  logic           ior,
  output logic [15:0]    iordt,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] sq,
  output logic [NCH-1:0] flag
);
  logic [7:0] off;
  logic hit;
  logic [3:0] chan;
  logic [15:0] rdt [NCH];
  logic [15:0] rd_mux;
  assign off = ioad - IO_BASE;
  assign hit = (ioad >= IO_BASE) && (off < 8'(4 * NCH));
  assign chan = off[5:2];
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    tick_chan #(.DIV_W(DIV_W), .DEF_DIV(DEF_DIV), .DEF_EN(DEF_EN)) u_chan (
      .clk50(clk50),
      .reset_n(reset_n),
      .we(iow && hit && chan == 4'(i)),
      .re(ior && hit && chan == 4'(i)),
      .off(off_e'(off[1:0])),
      .wdt(iowdt),
      .rdt(rdt[i]),
      .tick(tick[i]),
      .sq(sq[i]),
      .flag(flag[i])
    );
  end
  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < NCH; c++) if (hit && chan == 4'(c)) rd_mux = rdt[c];
  end
  always_ff @(posedge clk50 or negedge reset_n)
    if (!reset_n) iordt <= '0;
    else if (ior) iordt <= rd_mux;
endmodule

// File: tb/tb_tick_div_bank.sv
// tb_tick_div_bank: table, directed and randomized checks of tick_div_bank
// against a cycle-level behavioural model of the register/tick rules
module tb_tick_div_bank;
  localparam int NCH = 4;
  localparam int DIV_W = 28;
  localparam logic [7:0] BASE = 8'h40;
  localparam int DEF_DIV = 50_000;

  logic clk50 = 1'b0, reset_n = 1'b0, iow = 1'b0, ior = 1'b0;
  logic [7:0] ioad = '0;
  logic [15:0] iowdt = '0, iordt;
  logic [NCH-1:0] tick, sq, flag;
  int n_tests = 0, n_fail = 0, cyc_n = 0;
  int tq [NCH][$];

  typedef struct {int shadow; int act; int cnt; bit en; bit os; bit sq; bit flag;} ch_t;
  ch_t m [NCH];
  int m_iordt;

  typedef struct packed {logic w; logic [7:0] a; logic [15:0] d; logic [15:0] exp;} vec_t;

  always #10 clk50 = ~clk50;

  tick_div_bank #(.NCH(NCH), .DIV_W(DIV_W), .IO_BASE(BASE), .DEF_DIV(DEF_DIV), .DEF_EN(1'b0)) dut (
    .clk50(clk50), .reset_n(reset_n), .ioad(ioad), .iowdt(iowdt), .iow(iow), .ior(ior),
    .iordt(iordt), .tick(tick), .sq(sq), .flag(flag)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc_n, act, exp);
    end
  endtask

  function automatic void m_reset();
    for (int c = 0; c < NCH; c++) m[c] = '{DEF_DIV, DEF_DIV, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    m_iordt = 0;
  endfunction

  function automatic bit m_tk(int c);
    int d = (m[c].act == 0) ? 1 : m[c].act;
    return m[c].en && m[c].cnt >= d - 1;
  endfunction

  function automatic logic [NCH-1:0] m_vec(int sel);
    logic [NCH-1:0] v;
    for (int c = 0; c < NCH; c++) v[c] = (sel == 0) ? m_tk(c) : (sel == 1) ? m[c].sq : m[c].flag;
    return v;
  endfunction

  function automatic int m_rd(logic [7:0] a);
    int off = int'(a) - int'(BASE);
    int c, r;
    if (off < 0 || off >= 4 * NCH) return 0;
    c = off / 4;
    r = off % 4;
    if (r == 0) return m[c].shadow & 'hFFFF;
    if (r == 1) return (m[c].shadow >> 16) & 'hFFF;
    if (r == 2) return (int'(m[c].os) << 1) | int'(m[c].en);
    return (int'(m[c].en) << 2) | (int'(m[c].sq) << 1) | int'(m[c].flag);
  endfunction

  // next state from the rules: terminal count first, then bus effects (writes win)
  function automatic void m_step(bit w, bit r, logic [7:0] a, logic [15:0] d);
    int off = int'(a) - int'(BASE);
    bit t;
    ch_t n;
    if (r) m_iordt = m_rd(a);
    for (int c = 0; c < NCH; c++) begin
      t = m_tk(c);
      n = m[c];
      if (t) begin
        n.cnt = 0; n.sq = !m[c].sq; n.flag = 1'b1; n.act = m[c].shadow;
        if (m[c].os) n.en = 1'b0;
      end else if (m[c].en) n.cnt = m[c].cnt + 1;
      else n.act = m[c].shadow;
      if (off >= 0 && off < 4 * NCH && off / 4 == c) begin
        if (r && off % 4 == 3 && !t) n.flag = 1'b0;
        if (w && off % 4 == 0) n.shadow = (m[c].shadow & 'h0FFF0000) | int'(d);
        if (w && off % 4 == 1) n.shadow = (m[c].shadow & 'hFFFF) | ((int'(d) & 'hFFF) << 16);
        if (w && off % 4 == 2) begin
          n.en = d[0]; n.os = d[1];
          if (d[2]) begin n.act = m[c].shadow; n.cnt = 0; end
          if (d[3]) begin n.cnt = 0; n.sq = 1'b0; end
        end
      end
      m[c] = n;
    end
  endfunction

  task automatic cyc(bit w, bit r, logic [7:0] a, logic [15:0] d);
    @(negedge clk50);
    cyc_n++;
    for (int c = 0; c < NCH; c++) if (tick[c]) tq[c].push_back(cyc_n);
    chk("tick", tick, m_vec(0));
    chk("sq", sq, m_vec(1));
    chk("flag", flag, m_vec(2));
    chk("iordt", iordt, m_iordt);
    iow = w; ior = r; ioad = a; iowdt = d;
    m_step(w, r, a, d);
  endtask

  task automatic idle(int n);
    repeat (n) cyc(1'b0, 1'b0, 8'h00, 16'h0);
  endtask

  task automatic rd_chk(string name, logic [7:0] a, logic [15:0] exp);
    cyc(1'b0, 1'b1, a, 16'h0);
    cyc(1'b0, 1'b0, 8'h00, 16'h0);
    chk(name, iordt, exp);
  endtask

  function automatic int first(int c);
    return tq[c].size() > 0 ? tq[c][0] : -1;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t tbl [18];
    int w, nt, bad, op, c, r, total;
    logic [7:0] a;
    logic [15:0] d;
    m_reset();
    repeat (3) @(negedge clk50);
    reset_n = 1'b1;
    idle(1000);
    total = 0;
    for (int k = 0; k < NCH; k++) total += tq[k].size();
    chk("t1_no_tick", total, 0);
    tbl = '{
      {1'b0, 8'h40, 16'h0, 16'hC350}, {1'b0, 8'h41, 16'h0, 16'h0000},
      {1'b0, 8'h42, 16'h0, 16'h0000}, {1'b0, 8'h43, 16'h0, 16'h0000},
      {1'b0, 8'h4F, 16'h0, 16'h0000}, {1'b0, 8'h3F, 16'h0, 16'h0000},
      {1'b0, 8'h50, 16'h0, 16'h0000}, {1'b1, 8'h45, 16'hFFFF, 16'h0},
      {1'b0, 8'h45, 16'h0, 16'h0FFF}, {1'b1, 8'h44, 16'h1234, 16'h0},
      {1'b0, 8'h44, 16'h0, 16'h1234}, {1'b1, 8'h46, 16'h000E, 16'h0},
      {1'b0, 8'h46, 16'h0, 16'h0002}, {1'b1, 8'h50, 16'hFFFF, 16'h0},
      {1'b0, 8'h4D, 16'h0, 16'h0000}, {1'b1, 8'h45, 16'h0000, 16'h0},
      {1'b1, 8'h44, 16'hC350, 16'h0}, {1'b1, 8'h46, 16'h0000, 16'h0}
    };
    foreach (tbl[k]) begin
      if (tbl[k].w) cyc(1'b1, 1'b0, tbl[k].a, tbl[k].d);
      else rd_chk($sformatf("tbl%0d", k), tbl[k].a, tbl[k].exp);
    end
    // divide by 4 on channel 0
    cyc(1'b1, 1'b0, 8'h40, 16'd4);
    cyc(1'b1, 1'b0, 8'h42, 16'h5);
    w = cyc_n;
    tq[0].delete();
    idle(40);
    chk("t2_first", first(0), w + 4);
    chk("t2_count", tq[0].size(), 10);
    bad = 0;
    for (int i = 1; i < tq[0].size(); i++) if (tq[0][i] - tq[0][i-1] != 4) bad++;
    chk("t2_period", bad, 0);
    chk("t2_flag", flag[0], 1);
    chk("t2_sq", sq[0], 1);
    // divisor change without LOAD takes effect after the running period
    cyc(1'b1, 1'b0, 8'h40, 16'd7);
    tq[0].delete();
    idle(30);
    chk("t3_first", first(0), w + 44);
    chk("t3_second", tq[0].size() > 1 ? tq[0][1] : -1, w + 51);
    chk("t3_third", tq[0].size() > 2 ? tq[0][2] : -1, w + 58);
    // one-shot on channel 2
    cyc(1'b1, 1'b0, 8'h48, 16'd10);
    cyc(1'b1, 1'b0, 8'h4A, 16'h7);
    w = cyc_n;
    tq[2].delete();
    idle(30);
    chk("t4_count", tq[2].size(), 1);
    chk("t4_when", first(2), w + 10);
    rd_chk("t4_stat", 8'h4B, 16'h3);
    // STAT read on a tick cycle keeps the flag; the next read clears it
    nt = tq[0][tq[0].size()-1];
    while (nt <= cyc_n) nt += 7;
    while (cyc_n + 1 < nt) idle(1);
    cyc(1'b0, 1'b1, 8'h43, 16'h0);
    chk("t5_coincide", tq[0][tq[0].size()-1], nt);
    cyc(1'b0, 1'b1, 8'h43, 16'h0);
    chk("t5_flag_kept", flag[0], 1);
    idle(1);
    chk("t5_flag_cleared", flag[0], 0);
    // divisors 0 and 1 tick every cycle
    cyc(1'b1, 1'b0, 8'h4C, 16'd0);
    cyc(1'b1, 1'b0, 8'h4E, 16'h5);
    w = cyc_n;
    tq[3].delete();
    idle(10);
    chk("t6_div0_count", tq[3].size(), 10);
    chk("t6_div0_first", first(3), w + 1);
    cyc(1'b1, 1'b0, 8'h4C, 16'd1);
    idle(10);
    chk("t6_div1_count", tq[3].size(), 21);
    // asynchronous reset mid-run
    #3 reset_n = 1'b0;
    #1;
    chk("rst_tick", tick, 0);
    chk("rst_sq", sq, 0);
    chk("rst_flag", flag, 0);
    chk("rst_iordt", iordt, 0);
    m_reset();
    @(negedge clk50);
    reset_n = 1'b1;
    rd_chk("rst_div3", 8'h4C, 16'hC350);
    rd_chk("rst_ctrl3", 8'h4E, 16'h0);
    rd_chk("rst_div0", 8'h40, 16'hC350);
    // randomized bus traffic against the model
    repeat (3000) begin
      op = $urandom_range(0, 9);
      c = $urandom_range(0, NCH - 1);
      r = $urandom_range(0, 3);
      a = BASE + 8'(4 * c + r);
      if ($urandom_range(0, 9) == 0) a = 8'($urandom);
      d = (r == 0) ? 16'($urandom_range(0, 12)) :
          (r == 1) ? (($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'h0) :
          16'($urandom_range(0, 15));
      if (op < 3) cyc(1'b1, 1'b0, a, d);
      else if (op < 5) cyc(1'b0, 1'b1, a, 16'h0);
      else if (op == 5) cyc(1'b1, 1'b1, a, d);
      else idle(1);
    end
    idle(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
